// File: rtl/ss_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package ss_pkg;

  // Phase of the scan sequencer within a digit slot.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2,
    ST_OFF   = 2'd3
  } scan_state_t;

  // All digit enables released (active-low).
  localparam logic [3:0] DIG_OFF = 4'b1111;

  // Active-low one-hot digit enable for slot index s.
  function automatic logic [3:0] onehot_n(input logic [1:0] s);
    return ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/ss_slot_tmr.sv
// Slot timer: counts clocks within a digit slot, advances the slot index on
// wrap and flags the last cycle of a slot and of a frame.
module ss_slot_tmr #(
  parameter int TICK_DIV = 10000,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic [1:0]       sel,
  output logic             slot_end,
  output logic             frame_end
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;

  // Next count/slot: park at slot 0 cycle 0 when cleared or disabled.
  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (clr || !en) begin
      cnt_d = '0;
      sel_d = 2'd0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      sel_d = sel_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter and slot index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sel_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

  assign cnt       = cnt_q;
  assign sel       = sel_q;
  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = (cnt_q == CNT_LAST) && (sel_q == 2'd3);

endmodule

// File: rtl/ss_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan sequencer: steps the digit select,
// blanks at every digit change, applies brightness PWM inside each slot and
// captures the digit codes once per frame so updates never tear mid-frame.
module ss_scan_ctrl
  import ss_pkg::*;
#(
  parameter int TICK_DIV = 10000,
  parameter int BLANK    = 16,
  parameter int CODE_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2:0]        bright,
  input  logic [CODE_W-1:0] d0,
  input  logic [CODE_W-1:0] d1,
  input  logic [CODE_W-1:0] d2,
  input  logic [CODE_W-1:0] d3,
  output logic [1:0]        sel,
  output logic [CODE_W-1:0] code,
  output logic [3:0]        dig,
  output logic              frame,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(TICK_DIV);
  // Cycles per slot available for the lit window after blanking.
  localparam int SPAN  = TICK_DIV - BLANK;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W:0]   BLANK_W  = (CNT_W + 1)'(BLANK);

  if (TICK_DIV < 4) begin : g_bad_tick_div
    $error("ss_scan_ctrl: TICK_DIV must be at least 4");
  end
  if (BLANK < 1 || BLANK >= TICK_DIV) begin : g_bad_blank
    $error("ss_scan_ctrl: BLANK must satisfy 1 <= BLANK < TICK_DIV");
  end

  scan_state_t      state_q, state_d;
  logic [CODE_W-1:0] shadow_q [4];
  logic [2:0]        bright_q;
  logic [CNT_W-1:0]  l_cur;
  logic [CNT_W-1:0]  cnt;
  logic              slot_end;
  logic              frame_end;
  logic              tmr_clr;

  // Lookahead of the timer for the coming cycle, so outputs can be registered.
  logic [CNT_W-1:0]  cnt_nxt;
  logic [1:0]        sel_nxt;
  logic              capture;

  logic [3:0]        dig_d, dig_q;
  logic [CODE_W-1:0] code_d, code_q;
  logic              frame_d, frame_q;

  // Holding the timer cleared while idle makes the first enabled cycle land
  // on cycle 0 of slot 0 rather than cycle 1.
  assign tmr_clr = (state_q == ST_IDLE);

  ss_slot_tmr #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_slot_tmr (
    .clk       (clk),
    .rst       (rst),
    .clr       (tmr_clr),
    .en        (en),
    .cnt       (cnt),
    .sel       (sel),
    .slot_end  (slot_end),
    .frame_end (frame_end)
  );

  // Lit-window length from the brightness captured for this frame:
  // SPAN*(bright+1)/8, truncated.
  assign l_cur = CNT_W'((SPAN * (int'(bright_q) + 1)) >> 3);

  // Next phase and timer lookahead; capture on entry to slot 0 cycle 0.
  always_comb begin
    state_d = state_q;
    cnt_nxt = '0;
    sel_nxt = 2'd0;
    capture = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_BLANK;
      capture = 1'b1;
    end else begin
      if (slot_end) begin
        cnt_nxt = '0;
        sel_nxt = sel + 2'd1;
        capture = frame_end;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
        sel_nxt = sel;
      end
      // Cycle 0 is always blank (BLANK >= 1), so the old window length is
      // never consulted on a capture cycle.
      if ({1'b0, cnt_nxt} < BLANK_W) begin
        state_d = ST_BLANK;
      end else if ({1'b0, cnt_nxt} < BLANK_W + {1'b0, l_cur}) begin
        state_d = ST_ON;
      end else begin
        state_d = ST_OFF;
      end
    end
  end

  // Registered output values for the coming cycle.
  always_comb begin
    dig_d   = DIG_OFF;
    code_d  = shadow_q[sel_nxt];
    frame_d = 1'b0;
    if (state_d == ST_ON) begin
      dig_d = onehot_n(sel_nxt);
    end
    if (capture) begin
      // The shadow is being loaded on this edge; slot 0 shows the new d0.
      code_d = d0;
    end
    if (en && (state_q != ST_IDLE) && (cnt_nxt == CNT_LAST) && (sel_nxt == 2'd3)) begin
      frame_d = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame capture of digit codes and brightness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= '0;
      end
      bright_q <= 3'd7;
    end else if (capture) begin
      shadow_q[0] <= d0;
      shadow_q[1] <= d1;
      shadow_q[2] <= d2;
      shadow_q[3] <= d3;
      bright_q    <= bright;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q   <= DIG_OFF;
      code_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      dig_q   <= dig_d;
      code_q  <= code_d;
      frame_q <= frame_d;
    end
  end

  assign dig       = dig_q;
  assign code      = code_q;
  assign frame     = frame_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ss_scan_ctrl.sv
// Directed bench for ss_scan_ctrl with TICK_DIV=16, BLANK=2.
module tb_ss_scan_ctrl;

  localparam int TD = 16;
  localparam int BL = 2;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic [2:0]    bright = 3'd7;
  logic [CW-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [1:0]    sel;
  logic [CW-1:0] code;
  logic [3:0]    dig;
  logic          frame;
  logic [1:0]    dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model of the scan position.
  bit            m_act = 1'b0;
  int            m_slot = 0;
  int            m_cnt  = 0;
  int            m_L    = 14;
  logic [CW-1:0] m_code [4] = '{5'd0, 5'd0, 5'd0, 5'd0};
  int            dut_frames = 0;
  int            mdl_frames = 0;

  // Hand-computed (16-2)*(b+1)>>3 for b = 0..7.
  int         L_TAB   [8] = '{1, 3, 5, 7, 8, 10, 12, 14};
  logic [3:0] DIG_TAB [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  ss_scan_ctrl #(
    .TICK_DIV (TD),
    .BLANK    (BL),
    .CODE_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bright    (bright),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .sel       (sel),
    .code      (code),
    .dig       (dig),
    .frame     (frame),
    .dbg_state (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_dig();
    if (!m_act || m_cnt < BL || m_cnt >= BL + m_L) return 4'b1111;
    return DIG_TAB[m_slot];
  endfunction

  function automatic logic [1:0] exp_state();
    if (!m_act) return 2'd0;
    if (m_cnt < BL) return 2'd1;
    if (m_cnt < BL + m_L) return 2'd2;
    return 2'd3;
  endfunction

  // Compare the current cycle against the model.
  task automatic check_cycle(input string tag);
    logic exp_frame;
    exp_frame = m_act && (m_slot == 3) && (m_cnt == TD - 1);
    chk({tag, ".dig"}, 32'(dig), 32'(exp_dig()));
    chk({tag, ".sel"}, 32'(sel), m_act ? 32'(m_slot) : 32'd0);
    chk({tag, ".frame"}, 32'(frame), 32'(exp_frame));
    chk({tag, ".state"}, 32'(dbg_state), 32'(exp_state()));
    chk({tag, ".onehot"}, 32'($countones(~dig) <= 1), 32'd1);
    if (m_act) begin
      chk({tag, ".code"}, 32'(code), 32'(m_code[m_slot]));
    end
    if (frame) dut_frames++;
    if (exp_frame) mdl_frames++;
  endtask

  // Advance one clock and step the model with the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    if (!en) begin
      m_act = 1'b0; m_slot = 0; m_cnt = 0;
    end else if (!m_act || (m_slot == 3 && m_cnt == TD - 1)) begin
      m_act = 1'b1; m_slot = 0; m_cnt = 0;
      m_code = '{d0, d1, d2, d3};
      m_L = L_TAB[bright];
    end else if (m_cnt == TD - 1) begin
      m_cnt = 0; m_slot++;
    end else begin
      m_cnt++;
    end
    #1;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check_cycle(tag);
      tick();
    end
  endtask

  initial begin
    // 1. Asynchronous reset with no clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst.dig", 32'(dig), 32'hF);
    chk("rst.sel", 32'(sel), 32'd0);
    chk("rst.code", 32'(code), 32'd0);
    chk("rst.frame", 32'(frame), 32'd0);
    chk("rst.state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run(3, "idle");

    // 2. Full brightness, codes 1..4.
    d0 = 5'd1; d1 = 5'd2; d2 = 5'd3; d3 = 5'd4;
    bright = 3'd7;
    en = 1'b1;
    tick();
    chk("t2.c0.dig", 32'(dig), 32'hF);
    chk("t2.c0.code", 32'(code), 32'd1);
    run(2, "t2");
    chk("t2.c2.dig", 32'(dig), 32'hE);
    run(8, "t2");
    bright = 3'd3;              // mid-frame change: no effect until next frame
    run(53, "t2");
    chk("t2.c63.frame", 32'(frame), 32'd1);
    chk("t2.c63.dig", 32'(dig), 32'h7);
    run(1, "t2");

    // 3. bright=3 frame (L=7), then bright=0 frame (L=1).
    run(8, "t3b3");
    chk("t3.b3.on_last", 32'(dig), 32'hE);
    tick();
    chk("t3.b3.off_first", 32'(dig), 32'hF);
    bright = 3'd0;
    run(55, "t3b3");
    run(2, "t3b0");
    chk("t3.b0.on", 32'(dig), 32'hE);
    tick();
    chk("t3.b0.off", 32'(dig), 32'hF);

    // 4. d0 changes in slot 2: seen only from the next frame.
    run(29, "t4");
    d0 = 5'd9;
    run(32, "t4");
    chk("t4.new_d0", 32'(code), 32'd9);
    bright = 3'd7;

    // 5. Drop en at cycle 5 of slot 1, reassert after 3 idle cycles.
    run(21, "t5");
    chk("t5.pre_drop.sel", 32'(sel), 32'd1);
    en = 1'b0;
    tick();
    chk("t5.drop.dig", 32'(dig), 32'hF);
    chk("t5.drop.sel", 32'(sel), 32'd0);
    chk("t5.drop.state", 32'(dbg_state), 32'd0);
    run(2, "t5idle");
    d0 = 5'd5; d1 = 5'd6; d2 = 5'd7; d3 = 5'd8;
    en = 1'b1;
    tick();
    chk("t5.restart.code", 32'(code), 32'd5);
    chk("t5.restart.state", 32'(dbg_state), 32'd1);
    run(62, "t5");
    en = 1'b0;                  // would-be frame cycle becomes idle
    tick();
    chk("t5.frame_supp", 32'(frame), 32'd0);
    en = 1'b1;
    tick();
    run(64, "t5full");

    // Mid-operation asynchronous reset.
    run(20, "prerst");
    #3 rst = 1'b1;
    #1;
    chk("arst.dig", 32'(dig), 32'hF);
    chk("arst.sel", 32'(sel), 32'd0);
    chk("arst.code", 32'(code), 32'd0);
    chk("arst.frame", 32'(frame), 32'd0);
    m_act = 1'b0; m_slot = 0; m_cnt = 0; m_L = 14;
    m_code = '{5'd0, 5'd0, 5'd0, 5'd0};
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    run(2, "postrst");

    // 6. Randomised enable/brightness/code activity.
    dut_frames = 0;
    mdl_frames = 0;
    for (int i = 0; i < 1000; i++) begin
      en = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 9) == 0) bright = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) begin
        d0 = 5'($urandom_range(0, 31));
        d1 = 5'($urandom_range(0, 31));
        d2 = 5'($urandom_range(0, 31));
        d3 = 5'($urandom_range(0, 31));
      end
      check_cycle("t6");
      if (m_act && m_cnt < BL) chk("t6.blank", 32'(dig), 32'hF);
      tick();
    end
    chk("t6.frame_count", 32'(dut_frames), 32'(mdl_frames));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
